// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, one-entry skid buffer and IF/ID register
// Absorbs I-cache and decoder stalls; applies late redirects without breaking the cache contract.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        icache_ren_o,
  output logic [31:0] icache_addr_o,
  input  logic [31:0] icache_rdata_i,
  input  logic        icache_stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_stall_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;

  logic [31:0] redirect_tgt;
  logic [31:0] pc_inc;
  logic        fire;

  assign redirect_tgt  = redirect_pc_i & ~32'h0000_0003;
  assign pc_inc        = pc_q + 32'd4;
  assign icache_ren_o  = (state_q != ST_HOLD);
  assign icache_addr_o = pc_q;
  assign fire          = icache_ren_o & ~icache_stall_i;

  assign inst_o  = inst_q;
  assign pc_o    = pc_out_q;
  assign valid_o = valid_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    valid_d    = valid_q;
    inst_d     = inst_q;
    pc_out_d   = pc_out_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;
    case (state_q)
      ST_RUN: begin
        if (redirect_i) begin
          // Squashes IF/ID even under id_stall; a stalled request must still complete.
          valid_d = 1'b0;
          inst_d  = NOP_INST;
          if (icache_stall_i) begin
            tgt_d   = redirect_tgt;
            state_d = ST_DRAIN;
          end else begin
            pc_d = redirect_tgt;
          end
        end else if (fire) begin
          pc_d = pc_inc;
          if (!id_stall_i) begin
            pc_out_d = pc_q;
            inst_d   = icache_rdata_i;
            valid_d  = 1'b1;
          end else begin
            buf_pc_d   = pc_q;
            buf_inst_d = icache_rdata_i;
            state_d    = ST_HOLD;
          end
        end else if (!id_stall_i) begin
          valid_d = 1'b0;
          inst_d  = NOP_INST;
        end
      end
      ST_HOLD: begin
        if (redirect_i) begin
          pc_d    = redirect_tgt;
          valid_d = 1'b0;
          inst_d  = NOP_INST;
          state_d = ST_RUN;
        end else if (!id_stall_i) begin
          pc_out_d = buf_pc_q;
          inst_d   = buf_inst_q;
          valid_d  = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_DRAIN: begin
        valid_d = 1'b0;
        inst_d  = NOP_INST;
        if (redirect_i) tgt_d = redirect_tgt;
        if (!icache_stall_i) begin
          pc_d    = redirect_i ? redirect_tgt : tgt_q;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      tgt_q      <= 32'd0;
      valid_q    <= 1'b0;
      inst_q     <= NOP_INST;
      pc_out_q   <= 32'd0;
      buf_pc_q   <= 32'd0;
      buf_inst_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      valid_q    <= valid_d;
      inst_q     <= inst_d;
      pc_out_q   <= pc_out_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_ren_o;
  logic [31:0] icache_addr_o;
  logic [31:0] icache_rdata_i;
  logic        icache_stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_stall_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        valid_o;

  localparam logic [31:0] PAT = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .icache_ren_o(icache_ren_o), .icache_addr_o(icache_addr_o),
    .icache_rdata_i(icache_rdata_i), .icache_stall_i(icache_stall_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .id_stall_i(id_stall_i),
    .inst_o(inst_o), .pc_o(pc_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  // Cache model: the word at an address is the address xor a fixed pattern.
  assign icache_rdata_i = icache_addr_o ^ PAT;

  typedef struct {
    logic        rdr;
    logic [31:0] rpc;
    logic        ids;
    logic        ics;
    logic [31:0] addr;
    logic        ren;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  vec_t        vecs[$];
  vec_t        exp_q[$];
  logic [31:0] exp_pc_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rdr, input logic [31:0] rpc, input logic ids, input logic ics,
                     input logic [31:0] addr, input logic ren, input logic vld, input logic [31:0] pc);
    vec_t v;
    v.rdr = rdr; v.rpc = rpc; v.ids = ids; v.ics = ics;
    v.addr = addr; v.ren = ren; v.vld = vld; v.pc = pc;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t        e;
    logic [31:0] held_addr;
    logic        held;
    int          accepted;

    rst = 1'b1; icache_stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; id_stall_i = 1'b0;

    //   rdr  rpc            ids  ics   addr           ren  vld  pc
    add(0, 32'h0,          0, 0,  32'h4,         1, 1, 32'h0);
    add(0, 32'h0,          0, 0,  32'h8,         1, 1, 32'h4);
    add(0, 32'h0,          0, 0,  32'hC,         1, 1, 32'h8);
    add(0, 32'h0,          0, 0,  32'h10,        1, 1, 32'hC);
    add(0, 32'h0,          0, 1,  32'h10,        1, 0, 32'hC);
    add(0, 32'h0,          0, 1,  32'h10,        1, 0, 32'hC);
    add(0, 32'h0,          0, 1,  32'h10,        1, 0, 32'hC);
    add(0, 32'h0,          0, 0,  32'h14,        1, 1, 32'h10);
    add(0, 32'h0,          0, 0,  32'h18,        1, 1, 32'h14);
    add(0, 32'h0,          0, 0,  32'h1C,        1, 1, 32'h18);
    add(0, 32'h0,          0, 0,  32'h20,        1, 1, 32'h1C);
    add(0, 32'h0,          1, 0,  32'h24,        0, 1, 32'h1C);
    add(0, 32'h0,          1, 0,  32'h24,        0, 1, 32'h1C);
    add(0, 32'h0,          0, 0,  32'h24,        1, 1, 32'h20);
    add(0, 32'h0,          0, 0,  32'h28,        1, 1, 32'h24);
    add(1, 32'h100,        1, 0,  32'h100,       1, 0, 32'h24);
    add(0, 32'h0,          0, 0,  32'h104,       1, 1, 32'h100);
    add(1, 32'h40,         0, 0,  32'h40,        1, 0, 32'h100);
    add(1, 32'h200,        0, 1,  32'h40,        1, 0, 32'h100);
    add(0, 32'h0,          0, 1,  32'h40,        1, 0, 32'h100);
    add(0, 32'h0,          0, 0,  32'h200,       1, 0, 32'h100);
    add(0, 32'h0,          0, 0,  32'h204,       1, 1, 32'h200);
    add(1, 32'h500,        0, 1,  32'h204,       1, 0, 32'h200);
    add(1, 32'h300,        0, 1,  32'h204,       1, 0, 32'h200);
    add(0, 32'h0,          0, 0,  32'h300,       1, 0, 32'h200);
    add(0, 32'h0,          0, 0,  32'h304,       1, 1, 32'h300);
    add(1, 32'h400,        0, 1,  32'h304,       1, 0, 32'h300);
    add(1, 32'h603,        0, 0,  32'h600,       1, 0, 32'h300);
    add(0, 32'h0,          0, 0,  32'h604,       1, 1, 32'h600);
    add(0, 32'h0,          1, 0,  32'h608,       0, 1, 32'h600);
    add(1, 32'h700,        1, 0,  32'h700,       1, 0, 32'h600);
    add(0, 32'h0,          0, 0,  32'h704,       1, 1, 32'h700);
    add(1, 32'hFFFF_FFFC,  0, 0,  32'hFFFF_FFFC, 1, 0, 32'h700);
    add(0, 32'h0,          0, 0,  32'h0,         1, 1, 32'hFFFF_FFFC);
    add(0, 32'h0,          0, 0,  32'h4,         1, 1, 32'h0);
    add(0, 32'h0,          1, 1,  32'h4,         1, 1, 32'h0);
    add(0, 32'h0,          0, 0,  32'h8,         1, 1, 32'h4);

    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", icache_addr_o, 32'h0);
    check("rst_ren", {31'd0, icache_ren_o}, 32'd1);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_inst", inst_o, NOP);
    check("rst_pc", pc_o, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      redirect_i = vecs[i].rdr; redirect_pc_i = vecs[i].rpc;
      id_stall_i = vecs[i].ids; icache_stall_i = vecs[i].ics;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("v%0d_addr", i), icache_addr_o, e.addr);
      check($sformatf("v%0d_ren", i), {31'd0, icache_ren_o}, {31'd0, e.ren});
      check($sformatf("v%0d_valid", i), {31'd0, valid_o}, {31'd0, e.vld});
      check($sformatf("v%0d_pc", i), pc_o, e.pc);
      check($sformatf("v%0d_inst", i), inst_o, e.vld ? (e.pc ^ PAT) : NOP);
    end
    redirect_i = 1'b0; icache_stall_i = 1'b0;

    // Reset while holding a skid-buffered instruction.
    id_stall_i = 1'b1;
    @(posedge clk);
    #1;
    check("hold_ren", {31'd0, icache_ren_o}, 32'd0);
    rst = 1'b1;
    #1;
    check("hrst_valid", {31'd0, valid_o}, 32'd0);
    check("hrst_inst", inst_o, NOP);
    check("hrst_addr", icache_addr_o, 32'h0);
    check("hrst_ren", {31'd0, icache_ren_o}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    id_stall_i = 1'b0;

    // Random stalls, no redirects: decoder must see 0,4,8,... exactly once each.
    for (int k = 0; k < 1000; k++) exp_pc_q.push_back(32'(k * 4));
    accepted = 0;
    for (int c = 0; c < 400; c++) begin
      icache_stall_i = ($urandom_range(0, 9) < 3);
      id_stall_i     = ($urandom_range(0, 9) < 3);
      if (valid_o && !id_stall_i) begin
        logic [31:0] ep;
        ep = exp_pc_q.pop_front();
        check("stream_pc", pc_o, ep);
        check("stream_inst", inst_o, ep ^ PAT);
        accepted++;
      end
      held      = icache_ren_o & icache_stall_i;
      held_addr = icache_addr_o;
      @(posedge clk);
      #1;
      if (held) check("addr_stable", icache_addr_o, held_addr);
    end
    check("stream_progress", {31'd0, accepted >= 40}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
